dist_pair_enumerator: RTL
=========================

DIST_PAIR_ENUMERATOR -- requirements
Module: dist_pair_enumerator

Interface
REQ-001 Parameter WORD_WIDTH, default 8, SHALL set the width of index and shape words.
REQ-002 Parameter DIST_WIDTH, default 3, SHALL set the width of the target distance.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL request one enumeration run.
REQ-006 Ports ksize, fw, ow, st, input, WORD_WIDTH each, SHALL carry the lowered filter length (FW*FH), filter width, output width and stride.
REQ-007 Port dr, input, DIST_WIDTH, SHALL carry the target redundant-output distance.
REQ-008 Port busy, output, 1, SHALL be high while a run is in progress.
REQ-009 Ports idx1 and idx2, output, WORD_WIDTH each, SHALL carry the smaller and larger index of a matching weight pair.
REQ-010 Port pair_valid, output, 1, SHALL mark idx1/idx2 as valid.
REQ-011 Port pair_ready, input, 1, SHALL accept the presented pair.
REQ-012 Port done, output, 1, SHALL pulse for exactly one cycle at the end of a run.
REQ-013 Port cfg_err, output, 1, SHALL flag a rejected configuration for the last run.
REQ-014 Port pair_cnt, output, 2*WORD_WIDTH, SHALL report the pairs emitted in the current or last run.

Function
REQ-015 The block SHALL emit every pair (i1, i2) with 0 <= i1 < i2 < ksize for which (ow-fw)*dv + d == dr*st, where d = i2-i1 and dv = i2/fw - i1/fw.
- This makes it the inverse of the forward distance calculation: a pair is emitted iff the forward calculation gives quotient == dr with zero remainder.
REQ-016 All comparison arithmetic SHALL be exact and unsigned in 2*WORD_WIDTH bits; dr*st SHALL be formed once per run.
REQ-017 Row/column tracking SHALL use incrementing counters that wrap at fw; no per-candidate divider SHALL be used.
REQ-018 FSM states SHALL be IDLE, SCAN, EMIT and DONE.
REQ-019 In IDLE, start=1 at a clock edge SHALL latch ksize, fw, ow, st and dr, clear pair_cnt and cfg_err, and move to SCAN with candidate (0,1).
REQ-020 If latched fw==0, st==0, ksize<2 or ow<fw, the block SHALL instead set cfg_err=1 and go directly to DONE.
REQ-021 SCAN SHALL evaluate exactly one candidate per cycle, in order i1 ascending, then i2 ascending.
REQ-022 On a match in SCAN, the block SHALL register idx1/idx2 and enter EMIT; otherwise it SHALL advance to the next candidate.
REQ-023 In EMIT, pair_valid SHALL be 1 and idx1/idx2 SHALL stay stable until pair_ready=1.
REQ-024 On a pair_valid & pair_ready edge, pair_cnt SHALL increment and the candidate SHALL advance; the next state SHALL be SCAN, or DONE if the accepted pair was the last candidate.
REQ-025 After the last candidate (ksize-2, ksize-1) is evaluated without a match, the next state SHALL be DONE.
REQ-026 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-027 busy SHALL be high in SCAN, EMIT and DONE.
REQ-028 start SHALL be ignored when not in IDLE.
REQ-029 pair_cnt and cfg_err SHALL hold their values until the next accepted start.
REQ-030 With pair_ready held high, done SHALL be high in the cycle N+E after the start-accept edge, where N = ksize*(ksize-1)/2 and E = number of matches.
REQ-031 pair_valid SHALL never be high outside EMIT.

Reset
REQ-032 On reset assertion, the FSM SHALL go to IDLE immediately (asynchronously), including mid-run.
REQ-033 On reset, busy, pair_valid, done and cfg_err SHALL be 0, and idx1, idx2 and pair_cnt SHALL be 0.
REQ-034 After reset deasserts, the first accepted start SHALL begin a fresh run with no residue from an aborted run.

Verification
REQ-035 ksize=9, fw=3, ow=5, st=1, dr=1, pair_ready=1 -> pairs (0,1) (1,2) (3,4) (4,5) (6,7) (7,8); pair_cnt=6; done 42 cycles after start.
REQ-036 Same shape with dr=3 -> pairs (2,3) (5,6); pair_cnt=2.
REQ-037 ksize=9, fw=3, ow=5, st=2, dr=1 -> pairs (0,2) (3,5) (6,8); pair_cnt=3.
REQ-038 ow=2, fw=3 -> cfg_err=1, no pair_valid, pair_cnt=0, one-cycle done, then IDLE.
REQ-039 Case REQ-035 with pair_ready low for 4 cycles on the 2nd pair -> (1,2) held stable for those 4 cycles; final pair list and count unchanged; start pulses during the run are ignored.
REQ-040 Reset asserted while in EMIT -> all outputs 0 in the same cycle; a new run afterwards reproduces REQ-035 exactly.

Source files
------------

// File: rtl/dist_pair_enumerator.sv
// Enumerates weight-index pairs (i1 < i2 < ksize) whose redundant-output distance equals dr,
// one candidate per cycle, handing matches out over a valid/ready handshake.
module dist_pair_enumerator #(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   ksize,
  input  logic [WORD_WIDTH-1:0]   fw,
  input  logic [WORD_WIDTH-1:0]   ow,
  input  logic [WORD_WIDTH-1:0]   st,
  input  logic [DIST_WIDTH-1:0]   dr,
  output logic                    busy,
  output logic [WORD_WIDTH-1:0]   idx1,
  output logic [WORD_WIDTH-1:0]   idx2,
  output logic                    pair_valid,
  input  logic                    pair_ready,
  output logic                    done,
  output logic                    cfg_err,
  output logic [2*WORD_WIDTH-1:0] pair_cnt
);

  localparam int W  = WORD_WIDTH;
  localparam int PW = 2 * WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ks_q, ks_d, fw_q, fw_d, owfw_q, owfw_d;
  logic [PW-1:0]  target_q, target_d;
  logic [W-1:0]   i1_q, i1_d, i2_q, i2_d;
  logic [W-1:0]   c1_q, c1_d, c2_q, c2_d, dv_q, dv_d;
  logic [W-1:0]   idx1_q, idx1_d, idx2_q, idx2_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  // Next-candidate values; c1/c2 are i1/i2 mod fw, dv is the row difference.
  logic [W-1:0]   i1_n, i2_n, c1_n, c2_n, dv_n, c1_inc;
  logic           last, match, c2_wrap;

  always_comb begin
    last    = (i1_q == ks_q - W'(2)) && (i2_q == ks_q - W'(1));
    match   = (PW'(owfw_q) * PW'(dv_q) + PW'(i2_q - i1_q)) == target_q;
    c1_inc  = (c1_q == fw_q - W'(1)) ? '0 : c1_q + W'(1);
    c2_wrap = (c2_q == fw_q - W'(1));
    if (i2_q == ks_q - W'(1)) begin
      i1_n = i1_q + W'(1);
      i2_n = i1_q + W'(2);
      c1_n = c1_inc;
      c2_n = (c1_inc == fw_q - W'(1)) ? '0 : c1_inc + W'(1);
      dv_n = (c1_inc == fw_q - W'(1)) ? W'(1) : '0;
    end else begin
      i1_n = i1_q;
      i2_n = i2_q + W'(1);
      c1_n = c1_q;
      c2_n = c2_wrap ? '0 : c2_q + W'(1);
      dv_n = dv_q + (c2_wrap ? W'(1) : '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    ks_d     = ks_q;
    fw_d     = fw_q;
    owfw_d   = owfw_q;
    target_d = target_q;
    i1_d     = i1_q;
    i2_d     = i2_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    dv_d     = dv_q;
    idx1_d   = idx1_q;
    idx2_d   = idx2_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        ks_d     = ksize;
        fw_d     = fw;
        owfw_d   = ow - fw;
        target_d = PW'(dr) * PW'(st);
        i1_d     = '0;
        i2_d     = W'(1);
        c1_d     = '0;
        c2_d     = (fw == W'(1)) ? '0 : W'(1);
        dv_d     = (fw == W'(1)) ? W'(1) : '0;
        cnt_d    = '0;
        if (fw == '0 || st == '0 || ksize < W'(2) || ow < fw) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          err_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          idx1_d  = i1_q;
          idx2_d  = i2_q;
          state_d = EMIT;
        end else begin
          {i1_d, i2_d, c1_d, c2_d, dv_d} = {i1_n, i2_n, c1_n, c2_n, dv_n};
          state_d = last ? DONE : SCAN;
        end
      end
      EMIT: if (pair_ready) begin
        cnt_d = cnt_q + PW'(1);
        {i1_d, i2_d, c1_d, c2_d, dv_d} = {i1_n, i2_n, c1_n, c2_n, dv_n};
        state_d = last ? DONE : SCAN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ks_q     <= '0;
      fw_q     <= '0;
      owfw_q   <= '0;
      target_q <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      dv_q     <= '0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ks_q     <= ks_d;
      fw_q     <= fw_d;
      owfw_q   <= owfw_d;
      target_q <= target_d;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      dv_q     <= dv_d;
      idx1_q   <= idx1_d;
      idx2_q   <= idx2_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign pair_valid = (state_q == EMIT);
  assign done       = (state_q == DONE);
  assign idx1       = idx1_q;
  assign idx2       = idx2_q;
  assign pair_cnt   = cnt_q;
  assign cfg_err    = err_q;

endmodule
